mnist_pixel_arbiter: RTL and testbench

Shares the single read port of the camera pixel RAM between two requesters: CPU single-pixel reads and a hardware scan engine. The scan engine streams one 28x28 MNIST image (784 pixels) from a programmable base address. The block sits between the pixel RAM (8-bit data, 12-bit address) and the CPU-side read interface. It arbitrates round-robin, tracks in-flight reads through a fixed-latency tag pipeline, and returns data to the requester that issued each read.

---
 rtl/mnist_pixel_arbiter.sv | 122 ++++++++++++
 tb/tb_mnist_pixel_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_pixel_arbiter.sv
// mnist_pixel_arbiter: round-robin share of the pixel RAM read port
// between CPU single reads and a 28x28 image scan engine.
module mnist_pixel_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int IMG_PIXELS = 784,
  parameter int RAM_LAT    = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              scan_start,
  input  logic [ADDR_W-1:0] scan_base,
  output logic              scan_busy,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  output logic              scan_last,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N_PIX = CNT_W'(IMG_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic              r_last_scan;
  logic [RAM_LAT:0]  r_tag_v;
  logic [RAM_LAT:0]  r_tag_scan;
  logic [RAM_LAT:0]  r_tag_last;

  logic              w_scan_req;
  logic              w_cpu_win;
  logic              w_scan_win;
  logic              w_any_win;
  logic              w_scan_is_last;
  logic              w_start;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_ret_cpu;
  logic              w_ret_scan;

  assign w_scan_req = (r_state == S_SCAN) && (r_issue_cnt < N_PIX);
  // On a tie the requester not granted last takes the slot
  assign w_cpu_win = cpu_req && (!w_scan_req || r_last_scan);
  assign w_scan_win = w_scan_req && !w_cpu_win;
  assign w_any_win = w_cpu_win | w_scan_win;
  assign w_scan_is_last = (r_issue_cnt == LAST_IDX);
  assign w_scan_addr = r_base + r_issue_cnt[ADDR_W-1:0];
  assign w_start = (r_state == S_IDLE) && scan_start;

  assign w_ret_cpu = r_tag_v[RAM_LAT] && !r_tag_scan[RAM_LAT];
  assign w_ret_scan = r_tag_v[RAM_LAT] && r_tag_scan[RAM_LAT];

  assign cpu_gnt = w_cpu_win;
  assign scan_busy = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (scan_start) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_scan_win && w_scan_is_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (scan_valid && scan_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_last_scan <= 1'b1;
      r_tag_v     <= '0;
      r_tag_scan  <= '0;
      r_tag_last  <= '0;
      ram_rd      <= 1'b0;
      ram_addr    <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      scan_valid  <= 1'b0;
      scan_last   <= 1'b0;
      scan_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_base      <= scan_base;
        r_issue_cnt <= '0;
      end else if (w_scan_win) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_any_win) begin
        r_last_scan <= w_scan_win;
        ram_addr    <= w_cpu_win ? cpu_addr : w_scan_addr;
      end
      ram_rd <= w_any_win;
      r_tag_v <= {r_tag_v[RAM_LAT-1:0], w_any_win};
      r_tag_scan <= {r_tag_scan[RAM_LAT-1:0], w_scan_win};
      r_tag_last <= {r_tag_last[RAM_LAT-1:0],
                     w_scan_win && w_scan_is_last};
      cpu_rvalid <= w_ret_cpu;
      scan_valid <= w_ret_scan;
      scan_last  <= w_ret_scan && r_tag_last[RAM_LAT];
      if (w_ret_cpu) cpu_rdata <= ram_rdata;
      if (w_ret_scan) scan_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mnist_pixel_arbiter.sv
// tb_mnist_pixel_arbiter: directed and random checks of the pixel
// RAM arbiter at RAM_LAT=1 and RAM_LAT=2.
module tb_mnist_pixel_arbiter;
  localparam int NPIX = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cpu_req, scan_start, sel;
  logic [11:0] cpu_addr, scan_base;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic g1, rv1, sv1, sl1, sb1, rd1;
  logic g2, rv2, sv2, sl2, sb2, rd2;
  logic [7:0] rdat1, sd1, rq1;
  logic [7:0] rdat2, sd2, rp2, rq2;
  logic [11:0] ra1, ra2;

  mnist_pixel_arbiter #(.RAM_LAT(1)) u_dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cpu_req(cpu_req & ~sel), .cpu_addr(cpu_addr),
    .cpu_gnt(g1), .cpu_rdata(rdat1), .cpu_rvalid(rv1),
    .scan_start(scan_start & ~sel), .scan_base(scan_base),
    .scan_busy(sb1), .scan_data(sd1), .scan_valid(sv1),
    .scan_last(sl1), .ram_rd(rd1), .ram_addr(ra1),
    .ram_rdata(rq1)
  );

  mnist_pixel_arbiter #(.RAM_LAT(2)) u_dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cpu_req(cpu_req & sel), .cpu_addr(cpu_addr),
    .cpu_gnt(g2), .cpu_rdata(rdat2), .cpu_rvalid(rv2),
    .scan_start(scan_start & sel), .scan_base(scan_base),
    .scan_busy(sb2), .scan_data(sd2), .scan_valid(sv2),
    .scan_last(sl2), .ram_rd(rd2), .ram_addr(ra2),
    .ram_rdata(rq2)
  );

  // RAM models: data = addr[7:0], RAM_LAT cycles after ram_rd
  always @(posedge clk) begin
    rq1 <= rd1 ? ra1[7:0] : 8'h5A;
    rp2 <= rd2 ? ra2[7:0] : 8'h5A;
    rq2 <= rp2;
  end

  logic m_gnt, m_rv, m_sv, m_sl, m_sb, m_rd;
  logic [7:0] m_rdat, m_sd;
  logic [11:0] m_ra;
  logic [32:0] m_outs;
  assign m_gnt = sel ? g2 : g1;
  assign m_rv = sel ? rv2 : rv1;
  assign m_sv = sel ? sv2 : sv1;
  assign m_sl = sel ? sl2 : sl1;
  assign m_sb = sel ? sb2 : sb1;
  assign m_rd = sel ? rd2 : rd1;
  assign m_rdat = sel ? rdat2 : rdat1;
  assign m_sd = sel ? sd2 : sd1;
  assign m_ra = sel ? ra2 : ra1;
  assign m_outs = {m_rv, m_rdat, m_sv, m_sl, m_sd, m_sb, m_rd, m_ra};

  logic [7:0] cpu_q[$];
  int cpu_t[$];
  logic [8:0] scan_q[$];
  int scan_t[$];
  logic [11:0] ram_q[$];

  always @(negedge clk) begin
    if (m_rv) begin
      cpu_q.push_back(m_rdat);
      cpu_t.push_back(cyc);
    end
    if (m_sv) begin
      scan_q.push_back({m_sl, m_sd});
      scan_t.push_back(cyc);
    end
    if (m_rd) ram_q.push_back(m_ra);
  end

  int n_chk = 0;
  int n_bad = 0;
  bit model_last_scan = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    cpu_q.delete();
    cpu_t.delete();
    scan_q.delete();
    scan_t.delete();
    ram_q.delete();
  endtask

  task automatic do_reset();
    drv();
    rst_n = 1'b0;
    cpu_req = 1'b0;
    scan_start = 1'b0;
    drv();
    rst_n = 1'b1;
    model_last_scan = 1'b1;
  endtask

  task automatic cpu_read(input logic [11:0] a, input int lat);
    int t;
    int k;
    drv();
    clear_q();
    cpu_req = 1'b1;
    cpu_addr = a;
    smp();
    t = cyc;
    chk("cpu_gnt", m_gnt, 1);
    drv();
    cpu_req = 1'b0;
    model_last_scan = 1'b0;
    k = 0;
    while (cpu_q.size() == 0 && k < 20) begin
      smp();
      k++;
    end
    repeat (4) smp();
    chk("cpu_rd_count", cpu_q.size(), 1);
    chk("cpu_rd_data", cpu_q.size() > 0 ? cpu_q[0] : 8'hxx, a[7:0]);
    chk("cpu_rd_lat", cpu_t.size() > 0 ? cpu_t[0] - t : -1, lat + 2);
  endtask

  // mode 0: scan alone, 1: CPU always requesting, 2: random CPU
  task automatic run_scan(input int mode, input logic [11:0] base,
                          input bit extra, input int lat);
    int s, issued, gnt_err, first_g, busy_fall, k, errs, t0, tn;
    logic [7:0] exp_cpu[$];
    logic [11:0] next_addr;
    logic [8:0] exp_fin;
    bit sp, ecpu, xfer;
    drv();
    clear_q();
    scan_start = 1'b1;
    scan_base = base;
    cpu_req = 1'b0;
    smp();
    s = cyc;
    chk("busy_before_start", m_sb, 0);
    issued = 0;
    gnt_err = 0;
    first_g = -1;
    busy_fall = -1;
    k = 0;
    xfer = 1'b0;
    next_addr = 12'h800;
    while (busy_fall < 0 && k < 2 * NPIX + 40) begin
      drv();
      scan_start = extra && (k == 100);
      scan_base = 12'h555;
      if (xfer || !cpu_req) begin
        cpu_req = 1'b0;
        if (mode == 1) begin
          cpu_req = 1'b1;
          cpu_addr = next_addr;
          next_addr = next_addr + 12'd1;
        end else if (mode == 2) begin
          cpu_req = 1'($urandom_range(0, 1));
          cpu_addr = 12'($urandom);
        end
      end
      smp();
      if (k == 0) chk("busy_after_start", m_sb, 1);
      sp = issued < NPIX;
      ecpu = cpu_req && (!sp || model_last_scan);
      if (m_gnt !== ecpu) gnt_err++;
      xfer = m_gnt;
      if (ecpu) begin
        exp_cpu.push_back(cpu_addr[7:0]);
        model_last_scan = 1'b0;
      end else if (sp) begin
        if (first_g < 0) first_g = cyc;
        issued++;
        model_last_scan = 1'b1;
      end
      if (!m_sb) busy_fall = cyc;
      k++;
    end
    drv();
    cpu_req = 1'b0;
    scan_start = 1'b0;
    repeat (lat + 4) smp();
    t0 = scan_t.size() > 0 ? scan_t[0] : -9999;
    tn = scan_t.size() > 0 ? scan_t[$] : -9999;
    exp_fin = {1'b1, 8'(base + 12'(NPIX - 1))};
    chk("gnt_pattern_errs", gnt_err, 0);
    chk("scan_count", scan_q.size(), NPIX);
    errs = 0;
    foreach (scan_q[i]) begin
      if (scan_q[i][7:0] !== 8'(base + 12'(i))) errs++;
      if (scan_q[i][8] !== (i == NPIX - 1)) errs++;
    end
    chk("scan_data_errs", errs, 0);
    chk("scan_final", scan_q.size() > 0 ? scan_q[$] : 9'hxxx, exp_fin);
    chk("scan_first_lat", t0 - first_g, lat + 2);
    chk("busy_fall", busy_fall - tn, 1);
    if (mode == 0) begin
      chk("scan_gapless", tn - t0, NPIX - 1);
      errs = (ram_q.size() == NPIX) ? 0 : 1;
      foreach (ram_q[i]) if (ram_q[i] !== 12'(base + 12'(i))) errs++;
      chk("scan_addr_errs", errs, 0);
    end
    if (mode == 1) chk("scan_bound", (tn - s) <= 2 * NPIX + 4, 1);
    chk("cpu_ret_count", cpu_q.size(), exp_cpu.size());
    errs = 0;
    foreach (exp_cpu[i])
      if (i >= cpu_q.size() || cpu_q[i] !== exp_cpu[i]) errs++;
    chk("cpu_ret_errs", errs, 0);
  endtask

  task automatic reset_mid();
    int k, n0, c0;
    drv();
    clear_q();
    scan_start = 1'b1;
    scan_base = 12'h000;
    drv();
    scan_start = 1'b0;
    k = 0;
    while (scan_q.size() < 300 && k < 400) begin
      smp();
      k++;
    end
    drv();
    cpu_req = 1'b1;
    cpu_addr = 12'h321;
    drv();
    cpu_req = 1'b0;
    rst_n = 1'b0;
    drv();
    rst_n = 1'b1;
    model_last_scan = 1'b1;
    smp();
    chk("rst_mid_outs", m_outs, 0);
    n0 = scan_q.size();
    c0 = cpu_q.size();
    repeat (12) smp();
    chk("rst_no_scan", scan_q.size() - n0, 0);
    chk("rst_no_cpu", cpu_q.size() - c0, 0);
    chk("rst_busy", m_sb, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0;
    scan_start = 1'b0;
    cpu_addr = '0;
    scan_base = '0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    smp();
    chk("reset_outs", m_outs, 0);
    chk("reset_gnt", m_gnt, 0);
    cpu_read(12'h123, 1);
    run_scan(0, 12'h000, 1'b1, 1);
    run_scan(0, 12'hF00, 1'b0, 1);
    run_scan(1, 12'h080, 1'b0, 1);
    run_scan(2, 12'($urandom), 1'b0, 1);
    run_scan(2, 12'($urandom), 1'b0, 1);
    reset_mid();
    cpu_read(12'h0AB, 1);
    sel = 1'b1;
    do_reset();
    cpu_read(12'h123, 2);
    run_scan(0, 12'h000, 1'b0, 2);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
